// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants and instruction field widths.
package mips_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;
  localparam int unsigned IMM_W = 16;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_id_stage_if.sv
// Signal bundle between fetch/execute and the IF/ID stage.
interface if_id_stage_if #(
    parameter int unsigned PC_W  = 30,
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      if_instr;
    logic [PC_W-1:0]  if_pc_plus1;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
    logic [31:0]      id_instr;
    logic [PC_W-1:0]  id_pc_plus1;
    logic             id_valid;
    logic             id_ex_bubble;
    logic             pc_hold;
    logic [31:0]      redirect_addr;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output if_instr, if_pc_plus1, ex_mem_read, ex_rt, rs_data, rt_data,
        input  id_instr, id_pc_plus1, id_valid, id_ex_bubble, pc_hold, redirect_addr,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  if_instr, if_pc_plus1, ex_mem_read, ex_rt, rs_data, rt_data,
        output id_instr, id_pc_plus1, id_valid, id_ex_bubble, pc_hold, redirect_addr,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Combinational load-use hazard detector for the instruction in ID.
module hazard_unit
    import mips_pkg::*;
(
    input  logic             valid,
    input  logic             mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [OP_W-1:0]  op,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic             stall
);
    logic uses_rt;

    always_comb begin
        uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
        stall   = valid && mem_read && (ex_rt != '0) &&
                  ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
    end
endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, ID-stage branch/jump resolution
// and saturating stall/flush counters.
module if_id_stage #(
    parameter int unsigned PC_W      = 30,
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst_n,
    if_id_stage_if.slave bus
);
    import mips_pkg::*;

    logic [31:0]      instr_q;
    logic [PC_W-1:0]  pc_q;
    logic             valid_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic [OP_W-1:0]  op;
    logic             stall;
    logic             taken;
    logic [PC_W-1:0]  target;

    assign op = instr_q[31:26];

    hazard_unit u_hazard (
        .valid    (valid_q),
        .mem_read (bus.ex_mem_read),
        .ex_rt    (bus.ex_rt),
        .op       (op),
        .rs       (instr_q[25:21]),
        .rt       (instr_q[20:16]),
        .stall    (stall)
    );

    always_comb begin
        taken  = 1'b0;
        target = pc_q + {{(PC_W-IMM_W){instr_q[15]}}, instr_q[15:0]};
        if (valid_q && !stall) begin
            case (op)
                OP_BEQ:  taken = (bus.rs_data == bus.rt_data);
                OP_BNE:  taken = (bus.rs_data != bus.rt_data);
                OP_J: begin
                    taken  = 1'b1;
                    target = {pc_q[PC_W-1:26], instr_q[25:0]};
                end
                default: taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q     <= NOP_INSTR;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (stall) begin
            if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
        end else if (taken) begin
            // Squash the wrong-path instruction fetched behind the branch.
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
        end else begin
            instr_q <= bus.if_instr;
            pc_q    <= bus.if_pc_plus1;
            valid_q <= 1'b1;
        end
    end

    assign bus.id_instr      = instr_q;
    assign bus.id_pc_plus1   = pc_q;
    assign bus.id_valid      = valid_q;
    assign bus.id_ex_bubble  = stall;
    assign bus.pc_hold       = stall;
    assign bus.redirect_addr = taken ? {target, 2'b00} : 32'h0;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage.
module tb_if_id_stage;
    localparam logic [31:0] ADD  = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] SUBU = 32'h00A1_3023; // subu $6,$5,$1
    localparam logic [31:0] BEQ  = 32'h1021_0002; // beq  $1,$1,+2
    localparam logic [31:0] BNE  = 32'h1421_0002; // bne  $1,$1,+2
    localparam logic [31:0] JMP  = 32'h0800_0002; // j    2

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    if_id_stage_if #(.PC_W(30), .CNT_W(16)) bus ();

    if_id_stage #(.PC_W(30), .CNT_W(16), .NOP_INSTR(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.if_instr    = ADD;
        bus.if_pc_plus1 = 30'd1;
        bus.ex_mem_read = 1'b0;
        bus.ex_rt       = 5'd0;
        bus.rs_data     = 32'd0;
        bus.rt_data     = 32'd0;
        tick();
        tick();
        check("rst_instr", bus.id_instr, 32'h0);
        check("rst_valid", {31'd0, bus.id_valid}, 32'd0);
        check("rst_hold", {31'd0, bus.pc_hold}, 32'd0);
        check("rst_bubble", {31'd0, bus.id_ex_bubble}, 32'd0);
        check("rst_redir", bus.redirect_addr, 32'h0);
        check("rst_cnts", {bus.stall_cnt, bus.flush_cnt}, 32'h0);
        rst_n = 1'b1;

        tick();
        check("add_instr", bus.id_instr, ADD);
        check("add_valid", {31'd0, bus.id_valid}, 32'd1);
        check("add_pc", {2'b0, bus.id_pc_plus1}, 32'd1);
        check("add_redir", bus.redirect_addr, 32'h0);
        check("add_hold", {31'd0, bus.pc_hold}, 32'd0);

        // Load-use on rs
        bus.if_instr = SUBU; bus.if_pc_plus1 = 30'd2;
        tick();
        check("subu_instr", bus.id_instr, SUBU);
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5;
        bus.if_instr = ADD; bus.if_pc_plus1 = 30'd3;
        #1;
        check("lu_hold", {31'd0, bus.pc_hold}, 32'd1);
        check("lu_bubble", {31'd0, bus.id_ex_bubble}, 32'd1);
        tick();
        bus.ex_mem_read = 1'b0;
        #1;
        check("lu_held_instr", bus.id_instr, SUBU);
        check("lu_held_pc", {2'b0, bus.id_pc_plus1}, 32'd2);
        check("lu_stall_cnt", {16'd0, bus.stall_cnt}, 32'd1);
        check("lu_released", {31'd0, bus.pc_hold}, 32'd0);
        // rt of an R-type also hazards; $0 never does
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd1;
        #1;
        check("lu_rt_hold", {31'd0, bus.pc_hold}, 32'd1);
        bus.ex_rt = 5'd0;
        #1;
        check("lu_r0_nohold", {31'd0, bus.pc_hold}, 32'd0);
        bus.ex_mem_read = 1'b0;

        // beq taken
        bus.if_instr = BEQ; bus.if_pc_plus1 = 30'd5;
        tick();
        bus.rs_data = 32'd1; bus.rt_data = 32'd1;
        bus.if_instr = ADD; bus.if_pc_plus1 = 30'd6;
        #1;
        check("beq_redir", bus.redirect_addr, 32'h1C);
        tick();
        check("beq_squash", bus.id_instr, 32'h0);
        check("beq_valid", {31'd0, bus.id_valid}, 32'd0);
        check("beq_flush", {16'd0, bus.flush_cnt}, 32'd1);
        check("bubble_redir", bus.redirect_addr, 32'h0);

        // bne not taken, then j
        bus.if_instr = BNE; bus.if_pc_plus1 = 30'd7;
        tick();
        bus.rs_data = 32'd3; bus.rt_data = 32'd3;
        bus.if_instr = JMP; bus.if_pc_plus1 = 30'd13;
        #1;
        check("bne_redir", bus.redirect_addr, 32'h0);
        tick();
        check("bne_adv", bus.id_instr, JMP);
        check("j_redir", bus.redirect_addr, 32'h08);
        tick();
        check("j_flush", {16'd0, bus.flush_cnt}, 32'd2);

        // Stall and branch in the same cycle
        bus.if_instr = BEQ; bus.if_pc_plus1 = 30'd5;
        tick();
        bus.rs_data = 32'd1; bus.rt_data = 32'd1;
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd1;
        bus.if_instr = ADD; bus.if_pc_plus1 = 30'd6;
        #1;
        check("col_redir0", bus.redirect_addr, 32'h0);
        check("col_hold", {31'd0, bus.pc_hold}, 32'd1);
        tick();
        bus.ex_mem_read = 1'b0;
        #1;
        check("col_held", bus.id_instr, BEQ);
        check("col_stall_cnt", {16'd0, bus.stall_cnt}, 32'd2);
        check("col_redir1", bus.redirect_addr, 32'h1C);
        bus.if_instr = SUBU; bus.if_pc_plus1 = 30'd2;
        tick();
        check("col_flush", {16'd0, bus.flush_cnt}, 32'd3);
        tick();
        check("col_flush_once", {16'd0, bus.flush_cnt}, 32'd3);
        check("col_next", bus.id_instr, SUBU);

        // Saturate the stall counter
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5;
        for (int i = 0; i < 65539; i++) tick();
        check("sat_stall_cnt", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);
        check("sat_hold", {31'd0, bus.pc_hold}, 32'd1);

        // Async reset mid-stall, between edges
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_instr", bus.id_instr, 32'h0);
        check("arst_valid", {31'd0, bus.id_valid}, 32'd0);
        check("arst_cnts", {bus.stall_cnt, bus.flush_cnt}, 32'h0);
        check("arst_hold", {31'd0, bus.pc_hold}, 32'd0);
        check("arst_bubble", {31'd0, bus.id_ex_bubble}, 32'd0);
        bus.ex_mem_read = 1'b0;
        bus.if_instr = ADD; bus.if_pc_plus1 = 30'd1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_capture", bus.id_instr, ADD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
